// File: rtl/wishbone_arbiter_rr.sv
// Round-robin arbiter sharing one Wishbone classic target among NUM_REQ requesters,
// with an optional ack timeout that aborts a stalled transfer.
//
// state | meaning
// IDLE  | no owner; arbitrating from ptr on any cyc request
// BUSY  | owner connected combinationally to the target
// ABORT | target timed out; owner sees err until it drops cyc
module wishbone_arbiter_rr #(
  parameter int NUM_REQ   = 2,
  parameter int DAT_WIDTH = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_REQ-1:0]             m_cyc_i,
  input  logic [NUM_REQ-1:0]             m_stb_i,
  input  logic [NUM_REQ-1:0]             m_we_i,
  input  logic [NUM_REQ*DAT_WIDTH-1:0]   m_dat_i,
  output logic [NUM_REQ-1:0]             m_ack_o,
  output logic [NUM_REQ-1:0]             m_err_o,
  output logic [DAT_WIDTH-1:0]           m_dat_o,
  output logic                           s_cyc_o,
  output logic                           s_stb_o,
  output logic                           s_we_o,
  output logic [DAT_WIDTH-1:0]           s_dat_o,
  input  logic [DAT_WIDTH-1:0]           s_dat_i,
  input  logic                           s_ack_i,
  output logic [NUM_REQ-1:0]             gnt_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW:0]   NUM_REQ_W = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] TMO_LAST  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t               state;
  logic [NUM_REQ-1:0]   gnt;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        ptr;
  logic [CW-1:0]        cnt;

  logic [IW:0]          scan;
  logic                 win_vld;
  logic [IW-1:0]        win_idx;
  logic [IW-1:0]        next_ptr;
  logic                 own_cyc, own_stb, own_we;
  logic [DAT_WIDTH-1:0] own_dat;
  logic                 tmo_hit;

  // Rotating priority search starting at ptr.
  always_comb begin
    scan    = '0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr} + (IW+1)'(k);
      if (scan >= NUM_REQ_W) scan = scan - NUM_REQ_W;
      if (!win_vld && m_cyc_i[scan[IW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = scan[IW-1:0];
      end
    end
  end

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        own_cyc = m_cyc_i[i];
        own_stb = m_stb_i[i];
        own_we  = m_we_i[i];
        own_dat = m_dat_i[i*DAT_WIDTH +: DAT_WIDTH];
      end
    end
  end

  assign next_ptr = (owner == LAST_IDX) ? '0 : owner + IW'(1);

  // Outputs are gated by state, so an asynchronous reset silences the target side at once.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (state == BUSY) begin
      s_cyc_o = own_cyc;
      s_stb_o = own_stb & own_cyc;
      s_we_o  = own_we;
      s_dat_o = own_dat;
      m_ack_o = gnt & {NUM_REQ{s_ack_i}};
    end else if (state == ABORT) begin
      m_err_o = gnt;
    end
  end

  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt;

  // Ack beats the timeout when both land in the same cycle.
  assign tmo_hit = (TIMEOUT > 0) && (state == BUSY) && s_stb_o && !s_ack_i && (cnt == TMO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state <= BUSY;
            gnt   <= NUM_REQ'(1) << win_idx;
            owner <= win_idx;
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (!own_cyc) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= next_ptr;
            cnt   <= '0;
          end else if (tmo_hit) begin
            state <= ABORT;
          end else if (s_ack_i) begin
            cnt <= '0;
          end else if (s_stb_o && cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
          end
        end
        ABORT: begin
          if (!own_cyc) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= next_ptr;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter_rr.sv
// Bench for wishbone_arbiter_rr: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of ownership, rotation and timeout.
module tb_wishbone_arbiter_rr;
  localparam int N   = 2;
  localparam int DW  = 8;
  localparam int TMO = 4;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [N-1:0]    m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
  logic [N*DW-1:0] m_dat_i = '0;
  logic [N-1:0]    m_ack_o, m_err_o, gnt_o;
  logic [DW-1:0]   m_dat_o, s_dat_o;
  logic [DW-1:0]   s_dat_i = '0;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic            s_ack_i = 1'b0;

  int n_cmp = 0, n_bad = 0, cyc_no = 0;

  // Model: current owner (-1 when free), next-priority index, stalled strobes, aborted flag.
  int own = -1, rr = 0, waited = 0;
  bit abt = 1'b0;

  always #5 clk_i = ~clk_i;

  wishbone_arbiter_rr #(.NUM_REQ(N), .DAT_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_dat_i(m_dat_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  function automatic bit bitat(input logic [N-1:0] v, input int i);
    return 1'(v >> i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h want %0h", tag, cyc_no, act, exp);
    end
  endtask

  task automatic model_reset();
    own = -1; rr = 0; waited = 0; abt = 1'b0;
  endtask

  task automatic check_outputs();
    logic [N-1:0]  e_gnt, e_ack, e_err;
    logic          e_cyc, e_stb, e_we;
    logic [DW-1:0] e_dat;
    e_gnt = '0; e_ack = '0; e_err = '0;
    e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_dat = '0;
    if (own >= 0) begin
      e_gnt = N'(1) << own;
      if (abt) e_err = e_gnt;
      else begin
        e_cyc = bitat(m_cyc_i, own);
        e_stb = bitat(m_stb_i, own) & bitat(m_cyc_i, own);
        e_we  = bitat(m_we_i, own);
        e_dat = DW'(m_dat_i >> (DW * own));
        e_ack = s_ack_i ? e_gnt : '0;
      end
    end
    chk("gnt", 32'(gnt_o), 32'(e_gnt));
    chk("s_cyc", 32'(s_cyc_o), 32'(e_cyc));
    chk("s_stb", 32'(s_stb_o), 32'(e_stb));
    chk("s_we", 32'(s_we_o), 32'(e_we));
    chk("s_dat", 32'(s_dat_o), 32'(e_dat));
    chk("m_ack", 32'(m_ack_o), 32'(e_ack));
    chk("m_err", 32'(m_err_o), 32'(e_err));
    chk("m_dat", 32'(m_dat_o), 32'(s_dat_i));
  endtask

  task automatic model_edge();
    if (own < 0) begin
      for (int k = 0; k < N; k++) begin
        if (own < 0 && bitat(m_cyc_i, (rr + k) % N)) begin
          own = (rr + k) % N; waited = 0; abt = 1'b0;
        end
      end
    end else if (!bitat(m_cyc_i, own)) begin
      rr = (own + 1) % N; own = -1; abt = 1'b0;
    end else if (!abt) begin
      if (s_ack_i) waited = 0;
      else if (bitat(m_stb_i, own)) begin
        waited++;
        if (TMO > 0 && waited == TMO) abt = 1'b1;
      end
    end
  endtask

  // One clock cycle: drive at edge+1, check at edge+3, advance the model at the edge.
  task automatic drive(input logic [N-1:0] c, input logic [N-1:0] s, input logic [N-1:0] w,
                       input logic [N*DW-1:0] d, input logic a, input logic [DW-1:0] sd);
    m_cyc_i = c; m_stb_i = s; m_we_i = w; m_dat_i = d; s_ack_i = a; s_dat_i = sd;
    #2;
    check_outputs();
    @(posedge clk_i);
    model_edge();
    #1;
    cyc_no++;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
    chk("rst_s_stb", 32'(s_stb_o), 32'h0);
    check_outputs();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [N-1:0] rc;
    #2;
    do_reset();

    // single write from requester 0, ack two cycles after the first strobe
    drive(2'b01, 2'b01, 2'b01, 16'h00A5, 1'b0, 8'h00);
    chk("wr_gnt", 32'(gnt_o), 32'h1);
    drive(2'b01, 2'b01, 2'b01, 16'h00A5, 1'b0, 8'h00);
    drive(2'b01, 2'b01, 2'b01, 16'h00A5, 1'b0, 8'h00);
    drive(2'b01, 2'b01, 2'b01, 16'h00A5, 1'b1, 8'h00);
    drive(2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 8'h00);

    // contention and fairness: both request, owner drops after one ack
    do_reset();
    for (int r = 0; r < 4; r++) begin
      drive(2'b11, 2'b11, 2'b00, 16'h1122, 1'b0, 8'h55);
      drive(2'b11, 2'b11, 2'b00, 16'h1122, 1'b1, 8'h66);
      chk("fair_gnt", 32'(gnt_o), (r % 2 == 0) ? 32'h1 : 32'h2);
      drive((r % 2 == 0) ? 2'b10 : 2'b01, 2'b11, 2'b00, 16'h1122, 1'b0, 8'h00);
      chk("fair_gap", 32'(gnt_o), 32'h0);
    end

    // timeout: requester 1 reads, target never answers
    drive(2'b10, 2'b10, 2'b00, 16'h7700, 1'b0, 8'h00);
    for (int i = 0; i < TMO; i++) drive(2'b10, 2'b10, 2'b00, 16'h7700, 1'b0, 8'h00);
    chk("tmo_err", 32'(m_err_o), 32'h2);
    chk("tmo_cyc", 32'(s_cyc_o), 32'h0);
    drive(2'b10, 2'b10, 2'b00, 16'h7700, 1'b0, 8'h00);
    drive(2'b10, 2'b10, 2'b00, 16'h7700, 1'b0, 8'h00);
    chk("tmo_hold", 32'(m_err_o), 32'h2);
    drive(2'b00, 2'b00, 2'b00, 16'h0000, 1'b0, 8'h00);
    drive(2'b11, 2'b11, 2'b00, 16'h0000, 1'b0, 8'h00);
    chk("tmo_ptr", 32'(gnt_o), 32'h1);

    // ack arriving on the would-be timeout strobe
    for (int i = 0; i < TMO - 1; i++) drive(2'b11, 2'b11, 2'b00, 16'h0000, 1'b0, 8'h00);
    drive(2'b11, 2'b11, 2'b00, 16'h0000, 1'b1, 8'h3C);
    chk("edge_err", 32'(m_err_o), 32'h0);
    chk("edge_gnt", 32'(gnt_o), 32'h1);
    drive(2'b11, 2'b11, 2'b00, 16'h0000, 1'b0, 8'h00);
    chk("edge_busy_cyc", 32'(s_cyc_o), 32'h1);

    // reset mid-transfer while requester 1 owns the bus
    drive(2'b10, 2'b10, 2'b10, 16'hC300, 1'b0, 8'h00);
    drive(2'b10, 2'b10, 2'b10, 16'hC300, 1'b0, 8'h00);
    chk("pre_rst_stb", 32'(s_stb_o), 32'h1);
    #2;
    do_reset();
    drive(2'b11, 2'b11, 2'b00, 16'h0000, 1'b0, 8'h00);
    chk("post_rst_gnt", 32'(gnt_o), 32'h1);

    // random traffic with persistent cyc per requester
    rc = '0;
    for (int i = 0; i < 3000; i++) begin
      rc ^= N'($urandom) & N'($urandom) & N'($urandom);
      drive(rc, N'($urandom) | N'($urandom), N'($urandom), (N*DW)'($urandom),
            $urandom_range(0, 3) == 0, DW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wishbone_arbiter_rr.md
WISHBONE_ARBITER_RR -- requirements
Module: wishbone_arbiter_rr

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, number of Wishbone classic requesters (controllers), minimum 2.
REQ-002 The block SHALL have parameter DAT_WIDTH, default 8, data width of every data port.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, maximum wait in cycles for target ack; 0 disables the timeout.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset, with ports clk_i and rst_ni.
REQ-005 clk_i  in  1  clock; all state changes on the rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 m_cyc_i  in  NUM_REQ  per-requester cyc; bit i belongs to requester i.
REQ-008 m_stb_i  in  NUM_REQ  per-requester stb.
REQ-009 m_we_i  in  NUM_REQ  per-requester write enable.
REQ-010 m_dat_i  in  NUM_REQ*DAT_WIDTH  per-requester write data; requester i in bits [i*DAT_WIDTH +: DAT_WIDTH].
REQ-011 m_ack_o  out  NUM_REQ  per-requester ack.
REQ-012 m_err_o  out  NUM_REQ  per-requester timeout error.
REQ-013 m_dat_o  out  DAT_WIDTH  read data, broadcast to all requesters.
REQ-014 s_cyc_o, s_stb_o, s_we_o  out  1 each  shared target-side cyc/stb/we.
REQ-015 s_dat_o  out  DAT_WIDTH  target-side write data.
REQ-016 s_dat_i  in  DAT_WIDTH  target read data.
REQ-017 s_ack_i  in  1  target ack.
REQ-018 gnt_o  out  NUM_REQ  registered one-hot grant; all zero when no owner.

Function
REQ-019 The FSM SHALL have states IDLE, BUSY and ABORT.
REQ-020 In IDLE with any m_cyc_i bit set, the block SHALL grant the first requester with cyc set, searching from index ptr upward with wrap-around, and enter BUSY on the next edge (1-cycle grant latency).
REQ-021 In IDLE the block SHALL hold s_cyc_o, s_stb_o, s_we_o, s_dat_o, m_ack_o and m_err_o at 0.
REQ-022 In BUSY with owner g, outputs SHALL be combinational: s_cyc_o=m_cyc_i[g], s_stb_o=m_stb_i[g]&m_cyc_i[g], s_we_o=m_we_i[g], s_dat_o=requester g data, m_ack_o[g]=s_ack_i; all other m_ack_o bits SHALL be 0.
REQ-023 m_dat_o SHALL equal s_dat_i in every state.
REQ-024 The owner SHALL keep the grant across back-to-back cycles for as long as m_cyc_i[g] stays high.
REQ-025 In BUSY, when m_cyc_i[g]=0 at an edge, the block SHALL go to IDLE, clear gnt_o and set ptr=(g+1) mod NUM_REQ; the next owner is granted no earlier than one cycle later.
REQ-026 The wait counter SHALL be cleared on entry to BUSY and on any cycle with s_ack_i=1, and SHALL increment on each cycle with s_stb_o=1 and s_ack_i=0.
REQ-027 With TIMEOUT>0, when the counter equals TIMEOUT-1, s_stb_o=1 and s_ack_i=0, the block SHALL enter ABORT on the next edge.
REQ-028 If ack and the timeout condition coincide, ack SHALL win: the transfer completes and the block does not abort.
REQ-029 In ABORT, the block SHALL drive s_cyc_o, s_stb_o and m_ack_o to 0 and set m_err_o[g]=1, holding this until m_cyc_i[g]=0, then go to IDLE with ptr advanced as in REQ-025.
REQ-030 The counter width SHALL be clog2(TIMEOUT+1), with a minimum of 1, and the counter SHALL never wrap.
REQ-031 Requester inputs without a grant SHALL have no effect on the target side.

Reset
REQ-032 On rst_ni=0 the block SHALL asynchronously enter IDLE with gnt_o=0, ptr=0 and counter=0, forcing all s_* outputs, m_ack_o and m_err_o to 0 immediately, including when reset is asserted mid-cycle.
REQ-033 After rst_ni deasserts, the block SHALL arbitrate from requester 0 at the first rising edge.

Verification (NUM_REQ=2, DAT_WIDTH=8, TIMEOUT=4)
REQ-034 Single write: requester 0 drives cyc/stb/we=1 and dat=0xA5, target acks 2 cycles after s_stb_o -> gnt_o=01 after 1 cycle, s_dat_o=0xA5, m_ack_o=01 for one cycle, m_err_o=0.
REQ-035 Contention: both requesters raise cyc in the same cycle after reset -> requester 0 is served first, then after it drops cyc, gnt_o=00 for one cycle, then gnt_o=10.
REQ-036 Fairness: both requesters request continuously and each drops cyc after one ack -> grants alternate 01,10,01,10 with no starvation.
REQ-037 Timeout: requester 1 reads, target never acks -> after 4 stb cycles m_err_o=10, s_cyc_o=0, held until requester 1 drops cyc, then IDLE with ptr=0.
REQ-038 Ack on the timeout cycle: s_ack_i=1 in the 4th stb cycle with s_dat_i=0x3C -> m_ack_o set, m_dat_o=0x3C, no error, stays in BUSY.
REQ-039 Reset mid-transfer: rst_ni=0 while in BUSY with stb high -> s_cyc_o, s_stb_o and gnt_o go to 0 without waiting for a clock edge; after release, requester 0 wins the first arbitration.
